fir_trig_disc: RTL and testbench
================================

FIR_TRIG_DISC -- requirements
Module: fir_trig_disc

Interface
REQ-001 SHALL have parameter NLANES, default 4: samples per clock, lane 0 earliest in time.
REQ-002 SHALL have parameter FWIDTH, default 31: signed filtered-sample width.
REQ-003 SHALL have parameter HOLDOFF_W, default 16: holdoff counter width.
REQ-004 SHALL have parameter BPAUSE_LEN, default 8: baseline-pause extension, in cycles.
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- fin  in  NLANES*FWIDTH  filtered samples; lane i at bits [FWIDTH*(i+1)-1 : FWIDTH*i]
- fvalid_in  in  1  fin valid
- thresh_hi  in  FWIDTH signed  upper (arming) threshold
- thresh_lo  in  FWIDTH signed  lower (release) threshold
- mode  in  2  0 off, 1 self, 2 software, 3 self or software
- arm  in  1  level; enables triggering
- sw_trig  in  1  software trigger pulse
- holdoff  in  HOLDOFF_W  dead cycles after a trigger
- count_clr  in  1  clears trig_count
- tot  out  NLANES  per-lane time over threshold
- trig_out  out  1  one-cycle trigger pulse
- trig_lane  out  max(1,$clog2(NLANES))  lane of the crossing
- trig_src  out  1  0 self, 1 software
- trig_count  out  32  saturating trigger count
- bsum_pause  out  1  baseline-sum pause request
- busy  out  1  state is ABOVE or HOLDOFF

Function
REQ-006 SHALL compute a hysteresis "over" flag for each lane, chained lane 0 to NLANES-1 in one cycle:
- over[i] = prev ? (fin_i > thresh_lo) : (fin_i > thresh_hi)
- prev for lane 0 is the registered over[NLANES-1] from the previous cycle.
- prev for lane i>0 is over[i-1].
REQ-007 SHALL treat fvalid_in=0 as forcing all over[] to 0 and clearing the registered chain state.
REQ-008 SHALL register tot = over[] with latency 1 cycle from fin.
REQ-009 SHALL detect a rising edge at lane i when over[i]=1 and prev for lane i is 0; the self-trigger candidate SHALL be the lowest such i.
REQ-010 SHALL implement FSM states IDLE, ARMED, ABOVE, HOLDOFF, with reset state IDLE.
REQ-011 SHALL transition IDLE->ARMED when arm=1 and mode!=0.
REQ-012 SHALL accept triggers only in state ARMED:
- self trigger requires mode bit0 = 1 and a rising edge.
- software trigger requires mode bit1 = 1 and sw_trig = 1.
REQ-013 SHALL, on an accepted trigger, register trig_out=1 for exactly one cycle (latency 1), with trig_lane and trig_src held until the next trigger.
REQ-014 SHALL resolve simultaneous self and software triggers as one trigger with trig_src=0 and trig_lane = self lane; a software-only trigger SHALL give trig_lane=0.
REQ-015 SHALL choose the state after a trigger as follows:
- ABOVE if the trigger was self and over[NLANES-1]=1 in the same cycle.
- otherwise HOLDOFF if holdoff != 0.
- otherwise ARMED.
REQ-016 SHALL move ABOVE->HOLDOFF (or ARMED if holdoff=0) on the first cycle with over[NLANES-1]=0.
REQ-017 SHALL stay in HOLDOFF for exactly holdoff cycles, sampling holdoff at HOLDOFF entry, then return to ARMED.
REQ-018 SHALL force the next state to IDLE from any state when arm=0 or mode=0; this takes priority over triggers.
REQ-019 SHALL ignore sw_trig and rising edges outside state ARMED, with no queuing.
REQ-020 SHALL increment trig_count on each trig_out, saturating at 2^32-1; count_clr SHALL take priority over a simultaneous increment, giving 0.
REQ-021 SHALL drive bsum_pause=1 while any tot bit is 1, and for BPAUSE_LEN cycles after the last cycle with any tot bit set.
REQ-022 SHALL have tot independent of FSM state.

Reset
REQ-023 SHALL, on reset_n=0, asynchronously set:
- state IDLE
- tot, trig_out, trig_lane, trig_src, bsum_pause, busy all 0
- trig_count 0
- hysteresis chain state 0
- holdoff and pause counters 0
REQ-024 SHALL resume from IDLE when reset is released mid-operation, with no trigger pulse emitted.

Structure
REQ-025 SHALL place the FSM state encoding, the mode encodings and the trig_count width constant in shared package fir_trig_pkg.
REQ-026 SHALL have one sub-module, disc_lane_chain, containing the combinational hysteresis chain (REQ-006, REQ-009); the FSM and counters SHALL live at top level.

Verification
REQ-027 SHALL cover hysteresis: NLANES=4, hi=100, lo=50, armed mode 1, holdoff=0; lanes {0,120,80,40} -> tot=0110, trig_out=1, trig_lane=1, state ARMED the next cycle.
REQ-028 SHALL cover ABOVE and holdoff: lanes {0,0,0,200} for 3 cycles then 0, holdoff=5 -> one trig_out, trig_lane=3, busy high 3+5 cycles, then a rearmed crossing triggers again.
REQ-029 SHALL cover collision: sw_trig and self edge at lane 2 in one cycle, mode 3 -> single trig_out, trig_src=0, trig_lane=2, trig_count +1.
REQ-030 SHALL cover disarm and invalid input: arm=0 during HOLDOFF -> IDLE next cycle; with fvalid_in=0 and fin above hi -> tot=0000 and no trigger.
REQ-031 SHALL cover bsum_pause: single-cycle tot -> bsum_pause high for 1+8 cycles with BPAUSE_LEN=8.
REQ-032 SHALL cover saturation and reset: trig_count preloaded to 2^32-1, then trigger -> count unchanged; reset_n pulse mid-ABOVE -> all outputs 0, state IDLE.

Source files
------------

// File: rtl/fir_trig_pkg.sv
// rtl/fir_trig_pkg.sv - shared encodings for the threshold trigger discriminator
package fir_trig_pkg;

  localparam int TRIG_CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_ABOVE   = 2'd2,
    ST_HOLDOFF = 2'd3
  } disc_state_e;

  localparam logic [1:0] MODE_OFF  = 2'd0;
  localparam logic [1:0] MODE_SELF = 2'd1;
  localparam logic [1:0] MODE_SW   = 2'd2;
  localparam logic [1:0] MODE_BOTH = 2'd3;

  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/disc_lane_chain.sv
// rtl/disc_lane_chain.sv - combinational hysteresis chain across the lanes of one clock
module disc_lane_chain #(
  parameter int NLANES = 4,
  parameter int FWIDTH = 31,
  parameter int LANE_W = 2
) (
  input  logic [NLANES*FWIDTH-1:0] fin,
  input  logic                     fvalid,
  input  logic signed [FWIDTH-1:0] thresh_hi,
  input  logic signed [FWIDTH-1:0] thresh_lo,
  input  logic                     prev_in,
  output logic [NLANES-1:0]        over,
  output logic                     self_hit,
  output logic [LANE_W-1:0]        self_lane
);

  logic [NLANES-1:0]        rise;
  logic                     prev;
  logic signed [FWIDTH-1:0] lane_val;

  // Each lane's hysteresis state feeds the next, so lane 0 sees last cycle's final lane.
  always_comb begin
    over     = '0;
    rise     = '0;
    prev     = prev_in;
    lane_val = '0;
    for (int i = 0; i < NLANES; i++) begin
      lane_val = $signed(fin[i*FWIDTH +: FWIDTH]);
      if (fvalid) begin
        over[i] = prev ? (lane_val > thresh_lo) : (lane_val > thresh_hi);
      end
      rise[i] = over[i] & ~prev;
      prev    = over[i];
    end
  end

  always_comb begin
    self_hit  = |rise;
    self_lane = '0;
    for (int i = NLANES - 1; i >= 0; i--) begin
      if (rise[i]) begin
        self_lane = LANE_W'(i);
      end
    end
  end

endmodule

// File: rtl/fir_trig_disc.sv
// rtl/fir_trig_disc.sv - multi-lane hysteresis trigger with holdoff, counter and baseline pause
module fir_trig_disc
  import fir_trig_pkg::*;
#(
  parameter int NLANES     = 4,
  parameter int FWIDTH     = 31,
  parameter int HOLDOFF_W  = 16,
  parameter int BPAUSE_LEN = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NLANES*FWIDTH-1:0]     fin,
  input  logic                         fvalid_in,
  input  logic signed [FWIDTH-1:0]     thresh_hi,
  input  logic signed [FWIDTH-1:0]     thresh_lo,
  input  logic [1:0]                   mode,
  input  logic                         arm,
  input  logic                         sw_trig,
  input  logic [HOLDOFF_W-1:0]         holdoff,
  input  logic                         count_clr,
  output logic [NLANES-1:0]            tot,
  output logic                         trig_out,
  output logic [lane_w(NLANES)-1:0]    trig_lane,
  output logic                         trig_src,
  output logic [TRIG_CNT_W-1:0]        trig_count,
  output logic                         bsum_pause,
  output logic                         busy
);

  localparam int LANE_W  = lane_w(NLANES);
  localparam int PAUSE_W = $clog2(BPAUSE_LEN + 2);

  disc_state_e           state_q, state_d, post_state;
  logic                  chain_q, chain_d;
  logic [NLANES-1:0]     tot_q, tot_d;
  logic                  trig_out_q, trig_out_d;
  logic [LANE_W-1:0]     trig_lane_q, trig_lane_d;
  logic                  trig_src_q, trig_src_d;
  logic [TRIG_CNT_W-1:0] trig_count_q, trig_count_d;
  logic [HOLDOFF_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [PAUSE_W-1:0]    pause_cnt_q, pause_cnt_d;

  logic [NLANES-1:0]     over;
  logic                  self_hit;
  logic [LANE_W-1:0]     self_lane;
  logic                  self_ok, sw_ok, accept;

  disc_lane_chain #(
    .NLANES (NLANES),
    .FWIDTH (FWIDTH),
    .LANE_W (LANE_W)
  ) u_chain (
    .fin       (fin),
    .fvalid    (fvalid_in),
    .thresh_hi (thresh_hi),
    .thresh_lo (thresh_lo),
    .prev_in   (chain_q),
    .over      (over),
    .self_hit  (self_hit),
    .self_lane (self_lane)
  );

  assign chain_d = over[NLANES-1];
  assign tot_d   = over;
  assign self_ok = mode[0] & self_hit;
  assign sw_ok   = mode[1] & sw_trig;
  assign post_state = (holdoff != '0) ? ST_HOLDOFF : ST_ARMED;

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    trig_out_d  = 1'b0;
    trig_lane_d = trig_lane_q;
    trig_src_d  = trig_src_q;
    accept      = 1'b0;
    if (!arm || mode == MODE_OFF) begin
      state_d    = ST_IDLE;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_ARMED;
        ST_ARMED: begin
          if (self_ok || sw_ok) begin
            // A coincident self edge wins over software so the lane is reported.
            accept      = 1'b1;
            trig_out_d  = 1'b1;
            trig_src_d  = ~self_ok;
            trig_lane_d = self_ok ? self_lane : '0;
            if (self_ok && over[NLANES-1]) begin
              state_d = ST_ABOVE;
            end else begin
              state_d    = post_state;
              hold_cnt_d = holdoff;
            end
          end
        end
        ST_ABOVE: begin
          if (!over[NLANES-1]) begin
            state_d    = post_state;
            hold_cnt_d = holdoff;
          end
        end
        ST_HOLDOFF: begin
          if (hold_cnt_q <= HOLDOFF_W'(1)) begin
            state_d    = ST_ARMED;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q - HOLDOFF_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    trig_count_d = trig_count_q;
    if (count_clr) begin
      trig_count_d = '0;
    end else if (accept && trig_count_q != '1) begin
      trig_count_d = trig_count_q + TRIG_CNT_W'(1);
    end
  end

  // Pause counter reloads on every cycle with tot active and drains afterwards.
  always_comb begin
    pause_cnt_d = pause_cnt_q;
    if (|tot_q) begin
      pause_cnt_d = PAUSE_W'(BPAUSE_LEN);
    end else if (pause_cnt_q != '0) begin
      pause_cnt_d = pause_cnt_q - PAUSE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      chain_q      <= 1'b0;
      tot_q        <= '0;
      trig_out_q   <= 1'b0;
      trig_lane_q  <= '0;
      trig_src_q   <= 1'b0;
      trig_count_q <= '0;
      hold_cnt_q   <= '0;
      pause_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      chain_q      <= chain_d;
      tot_q        <= tot_d;
      trig_out_q   <= trig_out_d;
      trig_lane_q  <= trig_lane_d;
      trig_src_q   <= trig_src_d;
      trig_count_q <= trig_count_d;
      hold_cnt_q   <= hold_cnt_d;
      pause_cnt_q  <= pause_cnt_d;
    end
  end

  assign tot        = tot_q;
  assign trig_out   = trig_out_q;
  assign trig_lane  = trig_lane_q;
  assign trig_src   = trig_src_q;
  assign trig_count = trig_count_q;
  assign bsum_pause = (|tot_q) | (pause_cnt_q != '0);
  assign busy       = (state_q == ST_ABOVE) || (state_q == ST_HOLDOFF);

endmodule

// File: tb/tb_fir_trig_disc.sv
// tb/tb_fir_trig_disc.sv - directed scoreboard bench for fir_trig_disc
module tb_fir_trig_disc;
  import fir_trig_pkg::*;

  localparam int NL = 4;
  localparam int FW = 31;
  localparam int HW = 16;

  logic                 clk;
  logic                 reset_n;
  logic [NL*FW-1:0]     fin;
  logic                 fvalid_in;
  logic signed [FW-1:0] thresh_hi, thresh_lo;
  logic [1:0]           mode;
  logic                 arm, sw_trig, count_clr;
  logic [HW-1:0]        holdoff;
  logic [NL-1:0]        tot;
  logic                 trig_out, trig_src, bsum_pause, busy;
  logic [1:0]           trig_lane;
  logic [31:0]          trig_count;

  typedef struct {
    logic [1:0]  lane;
    logic        src;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   nbusy, nbsum;

  fir_trig_disc #(.NLANES(NL), .FWIDTH(FW), .HOLDOFF_W(HW), .BPAUSE_LEN(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .fin        (fin),
    .fvalid_in  (fvalid_in),
    .thresh_hi  (thresh_hi),
    .thresh_lo  (thresh_lo),
    .mode       (mode),
    .arm        (arm),
    .sw_trig    (sw_trig),
    .holdoff    (holdoff),
    .count_clr  (count_clr),
    .tot        (tot),
    .trig_out   (trig_out),
    .trig_lane  (trig_lane),
    .trig_src   (trig_src),
    .trig_count (trig_count),
    .bsum_pause (bsum_pause),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fin(input int l0, input int l1, input int l2, input int l3);
    int v[4];
    v = '{l0, l1, l2, l3};
    for (int i = 0; i < NL; i++) fin[i*FW +: FW] = FW'(v[i]);
  endtask

  task automatic push(input logic [1:0] lane, input logic src, input logic [31:0] cnt);
    exp_t e;
    e.lane = lane;
    e.src  = src;
    e.cnt  = cnt;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset_n && trig_out) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_trig: got trig_out=1 lane=%0d expected none at %0t", trig_lane, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("trig_lane", 32'(trig_lane), 32'(e.lane));
        chk("trig_src", 32'(trig_src), 32'(e.src));
        chk("trig_count", trig_count, e.cnt);
      end
    end
  end

  initial begin
    reset_n = 1'b0; fvalid_in = 1'b1; fin = '0;
    thresh_hi = 100; thresh_lo = 50;
    mode = 2'd1; arm = 1'b0; sw_trig = 1'b0; holdoff = '0; count_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tot", 32'(tot), 0);
    chk("rst_trig_out", 32'(trig_out), 0);
    chk("rst_count", trig_count, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_bsum", 32'(bsum_pause), 0);
    chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));

    reset_n = 1'b1; arm = 1'b1;
    step();
    chk("arm_state", 32'(dut.state_q), 32'(ST_ARMED));

    // hysteresis across lanes
    set_fin(0, 120, 80, 40);
    push(2'd1, 1'b0, 32'd1);
    step();
    chk("hyst_tot", 32'(tot), 32'b0110);
    chk("hyst_trig_out", 32'(trig_out), 1);
    chk("hyst_state", 32'(dut.state_q), 32'(ST_ARMED));
    set_fin(0, 0, 0, 0);
    nbsum = bsum_pause ? 1 : 0;
    for (int k = 0; k < 11; k++) begin
      step();
      if (bsum_pause) nbsum++;
    end
    chk("bsum_cycles", 32'(nbsum), 32'd9);

    // ABOVE then holdoff
    holdoff = 16'd5;
    set_fin(0, 0, 0, 200);
    push(2'd3, 1'b0, 32'd2);
    nbusy = 0;
    for (int k = 0; k < 12; k++) begin
      if (k == 3) set_fin(0, 0, 0, 0);
      step();
      if (busy) nbusy++;
    end
    chk("busy_cycles", 32'(nbusy), 32'd8);
    chk("rearm_state", 32'(dut.state_q), 32'(ST_ARMED));
    set_fin(0, 0, 0, 200);
    push(2'd3, 1'b0, 32'd3);
    step();
    chk("retrig_state", 32'(dut.state_q), 32'(ST_ABOVE));
    holdoff = '0;
    set_fin(0, 0, 0, 0);
    step();
    chk("above_exit_state", 32'(dut.state_q), 32'(ST_ARMED));

    // self and software in the same cycle
    mode = 2'd3; sw_trig = 1'b1;
    set_fin(0, 0, 150, 0);
    push(2'd2, 1'b0, 32'd4);
    step();
    chk("coll_count", trig_count, 32'd4);
    sw_trig = 1'b0;
    set_fin(0, 0, 0, 0);
    step();

    // software only, then disarm during holdoff
    mode = 2'd2; holdoff = 16'd3; sw_trig = 1'b1;
    push(2'd0, 1'b1, 32'd5);
    step();
    chk("sw_state", 32'(dut.state_q), 32'(ST_HOLDOFF));
    step();
    chk("sw_ignored_state", 32'(dut.state_q), 32'(ST_HOLDOFF));
    sw_trig = 1'b0; arm = 1'b0;
    step();
    chk("disarm_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("disarm_busy", 32'(busy), 0);

    // invalid input above threshold
    arm = 1'b1; mode = 2'd1; holdoff = '0;
    step();
    fvalid_in = 1'b0;
    set_fin(200, 200, 200, 200);
    step();
    chk("inval_tot", 32'(tot), 0);
    chk("inval_state", 32'(dut.state_q), 32'(ST_ARMED));
    fvalid_in = 1'b1;
    set_fin(0, 0, 0, 0);
    step();

    // saturation
    force dut.trig_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.trig_count_q;
    set_fin(200, 0, 0, 0);
    push(2'd0, 1'b0, 32'hFFFF_FFFF);
    step();
    set_fin(0, 0, 0, 0);
    step();
    chk("sat_count", trig_count, 32'hFFFF_FFFF);

    // clear wins over simultaneous increment
    count_clr = 1'b1;
    set_fin(200, 0, 0, 0);
    push(2'd0, 1'b0, 32'd0);
    step();
    count_clr = 1'b0;
    set_fin(0, 0, 0, 0);
    step();
    chk("clr_count", trig_count, 0);

    // reset while in ABOVE
    set_fin(0, 0, 0, 200);
    push(2'd3, 1'b0, 32'd1);
    step();
    chk("pre_rst_state", 32'(dut.state_q), 32'(ST_ABOVE));
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_tot", 32'(tot), 0);
    chk("mid_rst_trig_out", 32'(trig_out), 0);
    chk("mid_rst_lane", 32'(trig_lane), 0);
    chk("mid_rst_src", 32'(trig_src), 0);
    chk("mid_rst_count", trig_count, 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_bsum", 32'(bsum_pause), 0);
    chk("mid_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    set_fin(0, 0, 0, 0);
    #1;
    reset_n = 1'b1;
    step();
    chk("post_rst_state", 32'(dut.state_q), 32'(ST_ARMED));
    chk("post_rst_trig_out", 32'(trig_out), 0);
    repeat (3) step();
    chk("sb_empty", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
